// File: rtl/sccb_slave_model.sv
// SCCB responder that emulates an OV7670-style camera register file on the system clock.
// scl/sda are oversampled; sda is only ever pulled low or released.
module sccb_slave_model #(
    parameter logic [7:0]  DEV_ID  = 8'h42,
    parameter bit          ACK_EN  = 1'b1,
    parameter logic [15:0] PID_VAL = 16'h7673
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        scl,
    inout  wire         sda,
    output logic        reg_wen,
    output logic [7:0]  reg_waddr,
    output logic [7:0]  reg_wdata,
    output logic        busy,
    output logic [15:0] debug_out
);

    localparam logic [3:0] StIdle     = 4'd0;
    localparam logic [3:0] StId       = 4'd1;
    localparam logic [3:0] StIdAck    = 4'd2;
    localparam logic [3:0] StSub      = 4'd3;
    localparam logic [3:0] StSubAck   = 4'd4;
    localparam logic [3:0] StWdata    = 4'd5;
    localparam logic [3:0] StWdataAck = 4'd6;
    localparam logic [3:0] StRdata    = 4'd7;
    localparam logic [3:0] StRdataNa  = 4'd8;
    localparam logic [3:0] StIgnore   = 4'd9;

    logic       scl_s1_q, scl_s2_q, scl_h_q;
    logic       sda_s1_q, sda_s2_q, sda_h_q;
    logic       scl_rise, scl_fall, start_det, stop_det;
    logic [3:0] state_q;
    logic [3:0] bit_cnt_q;
    logic [7:0] shreg_q;
    logic [7:0] ptr_q;
    logic [7:0] rd_byte_q;
    logic [7:0] rd_data;
    logic       sda_oe_q;
    logic       id_hit_q;
    logic       id_rd_q;
    logic       mack_q;
    logic [7:0] regs [0:255];

    assign sda = sda_oe_q ? 1'b0 : 1'bz;

    // Synchronisers idle high so leaving reset never fakes a START/STOP.
    always_ff @(posedge clk) begin
        if (!rst) begin
            scl_s1_q <= 1'b1;
            scl_s2_q <= 1'b1;
            scl_h_q  <= 1'b1;
            sda_s1_q <= 1'b1;
            sda_s2_q <= 1'b1;
            sda_h_q  <= 1'b1;
        end else begin
            scl_s1_q <= scl;
            scl_s2_q <= scl_s1_q;
            scl_h_q  <= scl_s2_q;
            sda_s1_q <= sda;
            sda_s2_q <= sda_s1_q;
            sda_h_q  <= sda_s2_q;
        end
    end

    assign scl_rise  = scl_s2_q & ~scl_h_q;
    assign scl_fall  = ~scl_s2_q & scl_h_q;
    assign start_det = scl_s2_q & scl_h_q & sda_h_q & ~sda_s2_q;
    assign stop_det  = scl_s2_q & scl_h_q & ~sda_h_q & sda_s2_q;

    always_comb begin
        rd_data = regs[ptr_q];
        if (ptr_q == 8'h0A) begin
            rd_data = PID_VAL[15:8];
        end else if (ptr_q == 8'h0B) begin
            rd_data = PID_VAL[7:0];
        end
    end

    // Product-ID registers are read-only; writes to them are pulsed but dropped.
    always_ff @(posedge clk) begin
        if (reg_wen && reg_waddr != 8'h0A && reg_waddr != 8'h0B) begin
            regs[reg_waddr] <= reg_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= StIdle;
            bit_cnt_q <= 4'd0;
            shreg_q   <= 8'h00;
            ptr_q     <= 8'h00;
            rd_byte_q <= 8'h00;
            sda_oe_q  <= 1'b0;
            id_hit_q  <= 1'b0;
            id_rd_q   <= 1'b0;
            mack_q    <= 1'b0;
            reg_wen   <= 1'b0;
            reg_waddr <= 8'h00;
            reg_wdata <= 8'h00;
            busy      <= 1'b0;
            debug_out <= 16'h0000;
        end else begin
            reg_wen <= 1'b0;
            if (start_det) begin
                state_q   <= StId;
                bit_cnt_q <= 4'd0;
                busy      <= 1'b1;
                sda_oe_q  <= 1'b0;
            end else if (stop_det) begin
                state_q  <= StIdle;
                busy     <= 1'b0;
                sda_oe_q <= 1'b0;
            end else begin
                case (state_q)
                    StId, StSub, StWdata: begin
                        if (scl_rise && bit_cnt_q != 4'd8) begin
                            shreg_q   <= {shreg_q[6:0], sda_s2_q};
                            bit_cnt_q <= bit_cnt_q + 4'd1;
                        end else if (scl_fall && bit_cnt_q == 4'd8) begin
                            bit_cnt_q <= 4'd0;
                            sda_oe_q  <= ACK_EN;
                            if (state_q == StId) begin
                                id_hit_q <= (shreg_q == DEV_ID) || (shreg_q == (DEV_ID | 8'h01));
                                id_rd_q  <= shreg_q[0];
                                sda_oe_q <= ACK_EN &&
                                            ((shreg_q == DEV_ID) || (shreg_q == (DEV_ID | 8'h01)));
                                state_q  <= StIdAck;
                            end else if (state_q == StSub) begin
                                ptr_q   <= shreg_q;
                                state_q <= StSubAck;
                            end else begin
                                reg_wen   <= 1'b1;
                                reg_waddr <= ptr_q;
                                reg_wdata <= shreg_q;
                                debug_out <= {ptr_q, shreg_q};
                                ptr_q     <= ptr_q + 8'd1;
                                state_q   <= StWdataAck;
                            end
                        end
                    end
                    StIdAck: begin
                        if (scl_fall) begin
                            if (!id_hit_q) begin
                                sda_oe_q <= 1'b0;
                                state_q  <= StIgnore;
                            end else if (id_rd_q) begin
                                rd_byte_q <= rd_data;
                                sda_oe_q  <= ~rd_data[7];
                                debug_out <= {ptr_q, rd_data};
                                bit_cnt_q <= 4'd0;
                                state_q   <= StRdata;
                            end else begin
                                sda_oe_q <= 1'b0;
                                state_q  <= StSub;
                            end
                        end
                    end
                    StSubAck, StWdataAck: begin
                        if (scl_fall) begin
                            sda_oe_q <= 1'b0;
                            state_q  <= StWdata;
                        end
                    end
                    StRdata: begin
                        if (scl_rise) begin
                            bit_cnt_q <= bit_cnt_q + 4'd1;
                        end else if (scl_fall) begin
                            if (bit_cnt_q == 4'd8) begin
                                sda_oe_q <= 1'b0;
                                mack_q   <= 1'b0;
                                state_q  <= StRdataNa;
                            end else begin
                                // ~cnt selects bit 7-cnt: MSB first
                                sda_oe_q <= ~rd_byte_q[~bit_cnt_q[2:0]];
                            end
                        end
                    end
                    StRdataNa: begin
                        if (scl_rise) begin
                            if (sda_s2_q) begin
                                state_q <= StIgnore;
                            end else begin
                                ptr_q  <= ptr_q + 8'd1;
                                mack_q <= 1'b1;
                            end
                        end else if (scl_fall && mack_q) begin
                            mack_q    <= 1'b0;
                            rd_byte_q <= rd_data;
                            sda_oe_q  <= ~rd_data[7];
                            debug_out <= {ptr_q, rd_data};
                            bit_cnt_q <= 4'd0;
                            state_q   <= StRdata;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sccb_slave_model.sv
// Directed bench for sccb_slave_model: a bit-banged SCCB initiator with hand-computed expectations.
module tb_sccb_slave_model;

    localparam int H = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        m_scl = 1'b1;
    logic        m_low = 1'b0;
    wire         sda;
    logic        reg_wen;
    logic [7:0]  reg_waddr;
    logic [7:0]  reg_wdata;
    logic        busy;
    logic [15:0] debug_out;

    int n_tests = 0;
    int n_fail = 0;
    int wen_cnt = 0;
    int slave_low_cnt = 0;

    pullup (sda);
    assign sda = m_low ? 1'b0 : 1'bz;

    always #5 clk = ~clk;

    sccb_slave_model dut (
        .clk       (clk),
        .rst       (rst),
        .scl       (m_scl),
        .sda       (sda),
        .reg_wen   (reg_wen),
        .reg_waddr (reg_waddr),
        .reg_wdata (reg_wdata),
        .busy      (busy),
        .debug_out (debug_out)
    );

    always @(posedge clk) begin
        if (reg_wen) wen_cnt <= wen_cnt + 1;
        if (sda === 1'b0 && !m_low) slave_low_cnt <= slave_low_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic line();
        return (sda === 1'b0) ? 1'b0 : 1'b1;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bit_xfer(input logic b, output logic l);
        tick(2);
        m_low = ~b;
        tick(H - 2);
        m_scl = 1'b1;
        tick(H / 2);
        l = line();
        tick(H / 2);
        m_scl = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        logic l;
        for (int i = 7; i >= 0; i--) bit_xfer(b[i], l);
        bit_xfer(1'b1, l);
        ack = ~l;
    endtask

    task automatic recv_byte(input logic na, output logic [7:0] d);
        logic l;
        for (int i = 7; i >= 0; i--) begin
            bit_xfer(1'b1, l);
            d[i] = l;
        end
        bit_xfer(na, l);
    endtask

    task automatic do_start();
        tick(2);
        m_low = 1'b0;
        tick(H - 2);
        m_scl = 1'b1;
        tick(H);
        m_low = 1'b1;
        tick(H);
        m_scl = 1'b0;
    endtask

    task automatic do_stop();
        tick(2);
        m_low = 1'b1;
        tick(H - 2);
        m_scl = 1'b1;
        tick(H);
        m_low = 1'b0;
        tick(H);
    endtask

    initial begin
        logic       a;
        logic       l;
        logic [7:0] d;
        int         w0;
        int         s0;

        // Reset state
        tick(4);
        check("rst_wen", reg_wen, 1'b0);
        check("rst_waddr", reg_waddr, 8'h00);
        check("rst_wdata", reg_wdata, 8'h00);
        check("rst_busy", busy, 1'b0);
        check("rst_debug", debug_out, 16'h0000);
        check("rst_sda", line(), 1'b1);
        rst = 1'b1;
        tick(4);

        // 1: three-phase write
        w0 = wen_cnt;
        do_start();
        check("t1_busy", busy, 1'b1);
        send_byte(8'h42, a); check("t1_ack_id", a, 1'b1);
        send_byte(8'h12, a); check("t1_ack_sub", a, 1'b1);
        send_byte(8'h80, a); check("t1_ack_data", a, 1'b1);
        check("t1_wen_pulses", wen_cnt - w0, 1);
        check("t1_waddr", reg_waddr, 8'h12);
        check("t1_wdata", reg_wdata, 8'h80);
        check("t1_debug", debug_out, 16'h1280);
        do_stop();
        tick(4);
        check("t1_busy_after", busy, 1'b0);

        // 2: set pointer to PID hi, then read with NA
        w0 = wen_cnt;
        do_start();
        send_byte(8'h42, a); check("t2_ack_id", a, 1'b1);
        send_byte(8'h0A, a); check("t2_ack_sub", a, 1'b1);
        do_stop();
        do_start();
        send_byte(8'h43, a); check("t2_ack_rid", a, 1'b1);
        recv_byte(1'b1, d); check("t2_rd_pid_hi", d, 8'h76);
        do_stop();
        check("t2_debug", debug_out, 16'h0A76);
        check("t2_no_wen", wen_cnt - w0, 0);

        // Burst read across both PID bytes using a repeated START
        do_start();
        send_byte(8'h42, a);
        send_byte(8'h0A, a);
        do_start();
        send_byte(8'h43, a);
        recv_byte(1'b0, d); check("t2b_rd0", d, 8'h76);
        recv_byte(1'b1, d); check("t2b_rd1", d, 8'h73);
        do_stop();
        check("t2b_debug", debug_out, 16'h0B73);

        // Write to read-only 0x0B: pulsed but discarded
        w0 = wen_cnt;
        do_start();
        send_byte(8'h42, a);
        send_byte(8'h0B, a);
        send_byte(8'h55, a);
        do_stop();
        check("t2c_wen", wen_cnt - w0, 1);
        check("t2c_waddr", reg_waddr, 8'h0B);
        do_start();
        send_byte(8'h42, a);
        send_byte(8'h0B, a);
        do_start();
        send_byte(8'h43, a);
        recv_byte(1'b1, d); check("t2c_ro_kept", d, 8'h73);
        do_stop();

        // Earlier write readback
        do_start();
        send_byte(8'h42, a);
        send_byte(8'h12, a);
        do_start();
        send_byte(8'h43, a);
        recv_byte(1'b1, d); check("t1_readback", d, 8'h80);
        do_stop();

        // 3: pointer wrap 0xFF -> 0x00
        w0 = wen_cnt;
        do_start();
        send_byte(8'h42, a);
        send_byte(8'hFF, a);
        send_byte(8'h11, a); check("t3_ack_d0", a, 1'b1);
        send_byte(8'h22, a); check("t3_ack_d1", a, 1'b1);
        do_stop();
        check("t3_wen", wen_cnt - w0, 2);
        check("t3_waddr", reg_waddr, 8'h00);
        check("t3_wdata", reg_wdata, 8'h22);
        do_start();
        send_byte(8'h42, a);
        send_byte(8'hFF, a);
        do_start();
        send_byte(8'h43, a);
        recv_byte(1'b0, d); check("t3_rd_ff", d, 8'h11);
        recv_byte(1'b1, d); check("t3_rd_00", d, 8'h22);
        do_stop();
        check("t3_debug", debug_out, 16'h0022);

        // 4: foreign ID is ignored
        w0 = wen_cnt;
        s0 = slave_low_cnt;
        do_start();
        send_byte(8'h60, a); check("t4_nack_id", a, 1'b0);
        send_byte(8'h12, a); check("t4_nack_b1", a, 1'b0);
        send_byte(8'h34, a); check("t4_nack_b2", a, 1'b0);
        check("t4_busy", busy, 1'b1);
        do_stop();
        tick(4);
        check("t4_no_drive", slave_low_cnt - s0, 0);
        check("t4_no_wen", wen_cnt - w0, 0);
        check("t4_busy_after", busy, 1'b0);

        // 5: aborted byte leaves no trace
        do_start();
        send_byte(8'h42, a);
        send_byte(8'h30, a);
        send_byte(8'h5A, a);
        do_stop();
        w0 = wen_cnt;
        do_start();
        send_byte(8'h42, a);
        send_byte(8'h30, a);
        bit_xfer(1'b1, l);
        bit_xfer(1'b0, l);
        bit_xfer(1'b1, l);
        bit_xfer(1'b0, l);
        do_stop();
        tick(4);
        check("t5_abort_no_wen", wen_cnt - w0, 0);
        check("t5_abort_busy", busy, 1'b0);
        do_start();
        send_byte(8'h43, a);
        recv_byte(1'b1, d); check("t5_ptr_kept", d, 8'h5A);
        do_stop();
        w0 = wen_cnt;
        do_start();
        send_byte(8'h42, a);
        send_byte(8'h31, a);
        bit_xfer(1'b0, l);
        bit_xfer(1'b1, l);
        bit_xfer(1'b1, l);
        do_start();
        send_byte(8'h42, a); check("t5_rs_ack_id", a, 1'b1);
        send_byte(8'h31, a);
        send_byte(8'hC3, a); check("t5_rs_ack_data", a, 1'b1);
        do_stop();
        check("t5_rs_wen", wen_cnt - w0, 1);
        check("t5_rs_waddr", reg_waddr, 8'h31);
        check("t5_rs_wdata", reg_wdata, 8'hC3);

        // 6: reset while the slave holds an ack
        do_start();
        for (int i = 7; i >= 0; i--) begin
            d = 8'h42;
            bit_xfer(d[i], l);
        end
        tick(2);
        m_low = 1'b0;
        tick(3);
        check("t6_ack_drv", line(), 1'b0);
        rst = 1'b0;
        tick(1);
        check("t6_sda_rel", line(), 1'b1);
        check("t6_busy", busy, 1'b0);
        check("t6_wen", reg_wen, 1'b0);
        check("t6_waddr", reg_waddr, 8'h00);
        check("t6_wdata", reg_wdata, 8'h00);
        check("t6_debug", debug_out, 16'h0000);
        rst = 1'b1;
        tick(4);
        w0 = wen_cnt;
        do_start();
        send_byte(8'h42, a); check("t6_ack_id", a, 1'b1);
        send_byte(8'h44, a);
        send_byte(8'h99, a); check("t6_ack_data", a, 1'b1);
        do_stop();
        tick(4);
        check("t6_wen_cnt", wen_cnt - w0, 1);
        check("t6_new_waddr", reg_waddr, 8'h44);
        check("t6_new_wdata", reg_wdata, 8'h99);
        check("t6_busy_after", busy, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
